// File: rtl/sort_pkg.sv
// sort_pkg: shared types and sizing helpers for the sort_arbiter slice.
//   state_t      : arbiter job state (IDLE, START, WAIT, RESP)
//   pos_width()  : bits per position entry for a given vector length
//   owner_width(): bits needed to index a requester
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_INPUTVALS = 16;

  // A position entry is one bit wider than a plain index, matching the engine.
  function automatic int pos_width(input int vals);
    return $clog2(vals) + 1;
  endfunction

  // Never let the owner index collapse to zero width.
  function automatic int owner_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int POS_W   = pos_width(DEF_INPUTVALS);
  localparam int OWNER_W = owner_width(DEF_NREQ);

endpackage

// File: rtl/sort_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   valid      in  NREQ  request vector
//   last_grant in  OW    requester served most recently
//   any        out 1     at least one request present
//   winner     out OW    first valid requester after last_grant (wrapping)
module rr_pick
  import sort_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]              valid,
  input  logic [owner_width(NREQ)-1:0] last_grant,
  output logic                         any,
  output logic [owner_width(NREQ)-1:0] winner
);

  localparam int OW = owner_width(NREQ);

  int            cand;
  logic [OW-1:0] cand_idx;

  // Scan last_grant+1, +2, ... with wrap; the first hit wins, so the most
  // recently served requester is considered last.
  always_comb begin
    any      = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand     = (int'(last_grant) + i) % NREQ;
      cand_idx = OW'(cand);
      if (!any && valid[cand_idx]) begin
        any    = 1'b1;
        winner = cand_idx;
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/sort_arbiter.sv
// sort_arbiter: shares one insert_sort engine between NREQ requesters.
// Jobs are accepted round-robin, run one at a time through the engine's
// start/done protocol, and the result is returned to the owning requester.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        per-requester job handshake (ready is one-hot)
//   req_data                   per-requester unsorted vector
//   rsp_valid/rsp_ready        per-requester result handshake (valid one-hot)
//   rsp_sorted/rsp_positions   shared result buses
//   rsp_error                  job failed (engine error or watchdog expiry)
//   eng_start/eng_data         engine start pulse and registered vector
//   eng_done/eng_error         engine status
//   eng_sorted/eng_positions   engine results
//   eng_flush                  one-cycle engine reset request
//   busy                       a job is in progress
//   owner                      requester index of the current job
//
// Build option: define SORT_ARB_TIMEOUT_EN to enable a watchdog in WAIT
// that fails the job after TIMEOUT_CYCLES and flushes the engine.
module sort_arbiter
  import sort_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int INPUTVALS      = 16,
  parameter int INPUTBITWIDTHS = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [NREQ-1:0]                                    req_valid,
  output logic [NREQ-1:0]                                    req_ready,
  input  logic [NREQ-1:0][INPUTVALS-1:0][INPUTBITWIDTHS-1:0] req_data,
  output logic [NREQ-1:0]                                    rsp_valid,
  input  logic [NREQ-1:0]                                    rsp_ready,
  output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]           rsp_sorted,
  output logic [INPUTVALS-1:0][pos_width(INPUTVALS)-1:0]     rsp_positions,
  output logic                                               rsp_error,
  output logic                                               eng_start,
  output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]           eng_data,
  input  logic                                               eng_done,
  input  logic                                               eng_error,
  input  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]           eng_sorted,
  input  logic [INPUTVALS-1:0][pos_width(INPUTVALS)-1:0]     eng_positions,
  output logic                                               eng_flush,
  output logic                                               busy,
  output logic [owner_width(NREQ)-1:0]                       owner
);

  localparam int OW = owner_width(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t        state;
  state_t        state_next;
  logic [OW-1:0] last_grant;
  logic          pick_any;
  logic [OW-1:0] pick_winner;
  logic          accept;
  logic          take_done;
  logic          take_err;
  logic          resp_hs;
  logic          wd_expired;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_winner)
  );

`ifdef SORT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] wd_cnt;

  // Watchdog: zeroed while the engine is being started, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == START) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      wd_cnt <= wd_cnt;
    end
  end

  assign wd_expired = (state == WAIT) && (wd_cnt == CW'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_expired         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake/strobe outputs. In WAIT an engine error beats
  // done, and done beats watchdog expiry.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    eng_start  = 1'b0;
    eng_flush  = 1'b0;
    accept     = 1'b0;
    take_done  = 1'b0;
    take_err   = 1'b0;
    resp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready  = ONE_HOT0 << pick_winner;
          accept     = 1'b1;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        eng_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (eng_error) begin
          take_err   = 1'b1;
          state_next = RESP;
        end else if (eng_done) begin
          take_done  = 1'b1;
          state_next = RESP;
        end else if (wd_expired) begin
          take_err   = 1'b1;
          eng_flush  = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP: begin
        rsp_valid = ONE_HOT0 << owner;
        if (rsp_ready[owner]) begin
          resp_hs    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        eng_flush  = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Job capture: the vector and owner stay put until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_data <= '0;
      owner    <= '0;
    end else if (accept) begin
      eng_data <= req_data[pick_winner];
      owner    <= pick_winner;
    end else begin
      eng_data <= eng_data;
      owner    <= owner;
    end
  end

  // Result capture: a failed job leaves the previous sorted/positions intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_sorted    <= '0;
      rsp_positions <= '0;
      rsp_error     <= 1'b0;
    end else if (take_done) begin
      rsp_sorted    <= eng_sorted;
      rsp_positions <= eng_positions;
      rsp_error     <= 1'b0;
    end else if (take_err) begin
      rsp_error     <= 1'b1;
    end else begin
      rsp_error     <= rsp_error;
    end
  end

  // Round-robin pointer advances only when a response is taken; reset value
  // makes requester 0 first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OW'(NREQ - 1);
    end else if (resp_hs) begin
      last_grant <= owner;
    end else begin
      last_grant <= last_grant;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sort_arbiter.sv
module tb_sort_arbiter;

  localparam int NREQ = 4;
  localparam int IV   = 8;
  localparam int W    = 16;
  localparam int TO   = 8;
  localparam int PW   = $clog2(IV) + 1;
  localparam int OW   = $clog2(NREQ);
  localparam int IW   = $clog2(IV);

  typedef logic [IV-1:0][W-1:0]  vec_t;
  typedef logic [IV-1:0][PW-1:0] pos_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][IV-1:0][W-1:0] req_data;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  vec_t                  rsp_sorted;
  pos_t                  rsp_positions;
  logic                  rsp_error;
  logic                  eng_start;
  vec_t                  eng_data;
  logic                  eng_done;
  logic                  eng_error;
  vec_t                  eng_sorted;
  pos_t                  eng_positions;
  logic                  eng_flush;
  logic                  busy;
  logic [OW-1:0]         owner;

  int   errors = 0;
  int   checks = 0;
  int   model_last;
  vec_t exp_prev_s;
  pos_t exp_prev_p;

  always #5 clk = ~clk;

  sort_arbiter #(
    .NREQ(NREQ), .INPUTVALS(IV), .INPUTBITWIDTHS(W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sorted(rsp_sorted), .rsp_positions(rsp_positions), .rsp_error(rsp_error),
    .eng_start(eng_start), .eng_data(eng_data),
    .eng_done(eng_done), .eng_error(eng_error),
    .eng_sorted(eng_sorted), .eng_positions(eng_positions),
    .eng_flush(eng_flush), .busy(busy), .owner(owner)
  );

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] r;
    r = '0;
    for (int k = 0; k < NREQ; k++) if (k == i) r[OW'(k)] = 1'b1;
    return r;
  endfunction

  // First valid requester strictly after the last served one, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[OW'((last + k) % NREQ)]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Stable ascending sort by ranking: element i lands at the count of
  // elements that must precede it; position records its original index.
  function automatic void ref_sort(input vec_t v, output vec_t s, output pos_t p);
    int rank;
    s = '0;
    p = '0;
    for (int i = 0; i < IV; i++) begin
      rank = 0;
      for (int j = 0; j < IV; j++)
        if (v[IW'(j)] < v[IW'(i)] || (v[IW'(j)] == v[IW'(i)] && j < i)) rank++;
      s[IW'(rank)] = v[IW'(i)];
      p[IW'(rank)] = PW'(i);
    end
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < IV; k++) v[IW'(k)] = W'($urandom_range(0, 31));
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; rsp_ready = '0;
    eng_done = 1'b0; eng_error = 1'b0; eng_sorted = '0; eng_positions = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_last = NREQ - 1;
    exp_prev_s = '0;
    exp_prev_p = '0;
  endtask

  // Serve one job end to end: grant, start, engine stub, response, release.
  // mode 0 = engine done, 1 = engine error (done randomly too), 2 = engine silent.
  task automatic run_job(input bit keep, input int lat, input int bp, input int mode);
    int w; int waited; int flushes;
    logic [NREQ-1:0] oh;
    vec_t v, es, rs; pos_t ep, rp;
    bit exp_err;
    #1;
    w = model_pick(req_valid, model_last);
    if (w < 0) return;
    oh = onehot(w);
    v  = req_data[OW'(w)];
    checks++;
    if (req_ready !== oh) begin errors++; $display("FAIL grant: req_ready=%b expected %b", req_ready, oh); end
    @(negedge clk);
    if (keep) req_data[OW'(w)] = rand_vec(); else req_valid[OW'(w)] = 1'b0;
    #1;
    checks++;
    if (eng_start !== 1'b1) begin errors++; $display("FAIL start_pulse: eng_start=%b expected 1", eng_start); end
    checks++;
    if (owner !== OW'(w)) begin errors++; $display("FAIL owner: owner=%0d expected %0d", owner, w); end
    checks++;
    if (eng_data !== v) begin errors++; $display("FAIL eng_data: got %h expected %h", eng_data, v); end
    checks++;
    if (req_ready !== '0 || busy !== 1'b1) begin errors++; $display("FAIL start_state: req_ready=%b busy=%b expected 0 and 1", req_ready, busy); end
    if (mode == 2) begin
      flushes = 0; waited = 0;
      while (flushes == 0 && waited < 4 * TO) begin
        @(negedge clk); #1; waited++;
        if (eng_flush === 1'b1) flushes++;
        else if (rsp_valid !== '0 || eng_start !== 1'b0) begin
          errors++; checks++; $display("FAIL timeout_wait: rsp_valid=%b eng_start=%b expected 0", rsp_valid, eng_start);
        end
      end
      checks++;
      if (flushes != 1 || waited < TO || waited > TO + 1) begin errors++; $display("FAIL timeout_flush: flush seen=%0d after %0d cycles, expected 1 after %0d..%0d", flushes, waited, TO, TO + 1); end
      rsp_ready = (bp == 0) ? oh : ~oh;
      @(negedge clk); #1;
      checks++;
      if (eng_flush !== 1'b0) begin errors++; $display("FAIL flush_width: eng_flush=%b expected 0", eng_flush); end
      exp_err = 1'b1;
    end else begin
      for (int k = 0; k < lat; k++) begin
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== '0 || eng_start !== 1'b0 || eng_data !== v || req_ready !== '0) begin
          errors++; $display("FAIL wait_phase: rsp_valid=%b eng_start=%b req_ready=%b expected 0/0/0", rsp_valid, eng_start, req_ready);
        end
      end
      @(negedge clk);
      ref_sort(eng_data, es, ep);
      if (mode == 1) begin
        eng_error = 1'b1; eng_done = 1'($urandom_range(0, 1));
        eng_sorted = ~es; eng_positions = ~ep;
      end else begin
        eng_done = 1'b1; eng_sorted = es; eng_positions = ep;
      end
      rsp_ready = (bp == 0) ? oh : ~oh;
      @(negedge clk);
      eng_done = 1'b0; eng_error = 1'b0;
      exp_err = (mode == 1);
      #1;
    end
    ref_sort(v, rs, rp);
    if (exp_err) begin rs = exp_prev_s; rp = exp_prev_p; end
    checks++;
    if (rsp_valid !== oh) begin errors++; $display("FAIL rsp_valid: got %b expected %b", rsp_valid, oh); end
    checks++;
    if (rsp_error !== exp_err) begin errors++; $display("FAIL rsp_error: got %b expected %b", rsp_error, exp_err); end
    checks++;
    if (rsp_sorted !== rs) begin errors++; $display("FAIL rsp_sorted: got %h expected %h", rsp_sorted, rs); end
    checks++;
    if (rsp_positions !== rp) begin errors++; $display("FAIL rsp_positions: got %h expected %h", rsp_positions, rp); end
    for (int k = 0; k < bp; k++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== oh || rsp_sorted !== rs || rsp_error !== exp_err || req_ready !== '0) begin
        errors++; $display("FAIL backpressure: rsp_valid=%b req_ready=%b expected %b and 0", rsp_valid, req_ready, oh);
      end
    end
    if (bp > 0) rsp_ready = oh;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin errors++; $display("FAIL release: rsp_valid=%b busy=%b expected 0 and 0", rsp_valid, busy); end
    model_last = w;
    if (!exp_err) begin exp_prev_s = rs; exp_prev_p = rp; end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || eng_start !== 1'b0 || eng_flush !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_strobes: req_ready=%b rsp_valid=%b start=%b flush=%b busy=%b expected all 0", tag, req_ready, rsp_valid, eng_start, eng_flush, busy);
    end
    checks++;
    if (owner !== '0 || rsp_error !== 1'b0 || rsp_sorted !== '0 || rsp_positions !== '0 || eng_data !== '0) begin
      errors++; $display("FAIL %s_regs: owner=%0d err=%b sorted=%h eng_data=%h expected 0", tag, owner, rsp_error, rsp_sorted, eng_data);
    end
  endtask

  task automatic test_reset();
    for (int r = 0; r < NREQ; r++) req_data[OW'(r)] = rand_vec();
    do_reset();
    #1;
    check_reset_values("reset");
  endtask

  task automatic test_single_job();
    vec_t v;
    v = '0;
    for (int k = 0; k < IV; k++) v[IW'(k)] = W'(10 + $urandom_range(0, 40));
    v[0] = 16'd5; v[1] = 16'd3; v[2] = 16'd9; v[3] = 16'd1;
    req_data[2] = v;
    req_valid = 4'b0100;
    run_job(1'b0, 3, 0, 0);
    checks++;
    if (rsp_sorted[0] !== 16'd1 || rsp_sorted[1] !== 16'd3 || rsp_sorted[2] !== 16'd5 || rsp_sorted[3] !== 16'd9) begin
      errors++; $display("FAIL single_sorted_head: got %h expected 0009/0005/0003/0001 at the low end", rsp_sorted);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < NREQ; r++) req_data[OW'(r)] = rand_vec();
    req_valid = '1;
    for (int j = 0; j < NREQ + 1; j++) begin
      checks++;
      if (model_pick(req_valid, model_last) != (j % NREQ)) begin errors++; $display("FAIL rr_order: model pick %0d expected %0d", model_pick(req_valid, model_last), j % NREQ); end
      run_job(1'b1, $urandom_range(0, 3), 0, 0);
    end
  endtask

  task automatic test_backpressure();
    req_valid = '1;
    run_job(1'b1, 2, 10, 0);
  endtask

  task automatic test_engine_error();
    req_valid = '1;
    run_job(1'b1, 1, 2, 1);
    run_job(1'b1, 1, 0, 0);
  endtask

  task automatic test_reset_in_wait();
    int seen;
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("reset_in_wait");
    model_last = NREQ - 1; exp_prev_s = '0; exp_prev_p = '0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (rsp_valid !== '0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL dropped_job: rsp_valid seen %0d cycles expected 0", seen); end
    req_valid = '1;
    run_job(1'b1, 1, 0, 0);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] v;
    for (int j = 0; j < 30; j++) begin
      v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) if (v[OW'(r)] && !req_valid[OW'(r)]) req_data[OW'(r)] = rand_vec();
      req_valid = v;
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 3), ($urandom_range(0, 5) == 0) ? 1 : 0);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== '0 || busy !== 1'b0) begin errors++; $display("FAIL idle: req_ready=%b busy=%b expected 0", req_ready, busy); end
        @(negedge clk);
      end
    end
  endtask

`ifdef SORT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req_valid = '1;
    run_job(1'b1, 0, 1, 2);
    run_job(1'b1, 2, 0, 0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = '0; rsp_ready = '0; req_data = '0;
    eng_done = 1'b0; eng_error = 1'b0; eng_sorted = '0; eng_positions = '0;
    @(negedge clk);
    test_reset();
    test_single_job();
    test_round_robin();
    test_backpressure();
    test_engine_error();
`ifdef SORT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
